// File: rtl/keypad_scan.sv
`default_nettype none
//==============================================================================
// Module   : keypad_scan
// Purpose  : 4x4 hex keypad scanner with per-scan debounce and decimal entry.
// Revision : 1.0 - initial release
//==============================================================================
module keypad_scan #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        pressed,
  output logic [15:0] data_out
);

  localparam int c_tick_w = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int c_cnt_w  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SCAN_TICKS - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cnt_max   = c_cnt_w'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAND = 2'd1,
    S_HELD = 2'd2,
    S_REL  = 2'd3
  } state_t;

  logic [3:0]          r_row_s1;
  logic [3:0]          r_row_s2;
  logic [c_tick_w-1:0] r_tick;
  logic [1:0]          r_col_idx;
  logic [3:0]          r_snap0;
  logic [3:0]          r_snap1;
  logic [3:0]          r_snap2;
  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [3:0]          r_cand;
  logic                r_acc;
  logic                r_rel_done;

  logic                w_sample;
  logic                w_scan_done;
  logic [15:0]         w_keys;
  logic [4:0]          w_nkeys;
  logic [3:0]          w_one_idx;
  logic                w_none;
  logic                w_one;
  logic [3:0]          w_code;
  logic [c_cnt_w-1:0]  w_cnt_inc;
  logic [16:0]         w_shift;
  logic [15:0]         w_wrap;
  logic [15:0]         w_div;

  // Key index is row*4 + col.
  function automatic logic [3:0] key_to_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'h0;
      4'd13: code = 4'hF;
      4'd14: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign col         = ~(4'b0001 << r_col_idx);
  assign w_sample    = (r_tick == c_tick_last);
  assign w_scan_done = w_sample && (r_col_idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick    <= '0;
      r_col_idx <= 2'd0;
      r_snap0   <= 4'h0;
      r_snap1   <= 4'h0;
      r_snap2   <= 4'h0;
    end else if (w_sample) begin
      r_tick    <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      case (r_col_idx)
        2'd0:    r_snap0 <= ~r_row_s2;
        2'd1:    r_snap1 <= ~r_row_s2;
        2'd2:    r_snap2 <= ~r_row_s2;
        default: ;
      endcase
    end else begin
      r_tick <= r_tick + c_tick_w'(1);
    end
  end

  // The col3 sample is used live so the scan completes on its sample edge.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_keys[r*4 + 0] = r_snap0[r];
      w_keys[r*4 + 1] = r_snap1[r];
      w_keys[r*4 + 2] = r_snap2[r];
      w_keys[r*4 + 3] = ~r_row_s2[r];
    end
  end

  always_comb begin
    w_nkeys   = 5'd0;
    w_one_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_keys[i]) begin
        w_nkeys   = w_nkeys + 5'd1;
        w_one_idx = 4'(i);
      end
    end
  end

  assign w_none    = (w_nkeys == 5'd0);
  assign w_one     = (w_nkeys == 5'd1);
  assign w_code    = key_to_code(w_one_idx);
  assign w_cnt_inc = r_cnt + c_cnt_w'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cand     <= 4'h0;
      r_acc      <= 1'b0;
      r_rel_done <= 1'b0;
    end else begin
      r_acc      <= 1'b0;
      r_rel_done <= 1'b0;
      if (w_scan_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_one) begin
              r_cand <= w_code;
              if (DEBOUNCE_SCANS == 1) begin
                r_acc   <= 1'b1;
                r_state <= S_HELD;
              end else begin
                r_cnt   <= c_cnt_one;
                r_state <= S_CAND;
              end
            end
          end
          S_CAND: begin
            if (w_one && (w_code == r_cand)) begin
              if (w_cnt_inc == c_cnt_max) begin
                r_acc   <= 1'b1;
                r_state <= S_HELD;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else if (w_one) begin
              r_cand <= w_code;
              r_cnt  <= c_cnt_one;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_HELD: begin
            if (w_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                r_rel_done <= 1'b1;
                r_state    <= S_IDLE;
              end else begin
                r_cnt   <= c_cnt_one;
                r_state <= S_REL;
              end
            end
          end
          S_REL: begin
            if (w_none) begin
              if (w_cnt_inc == c_cnt_max) begin
                r_rel_done <= 1'b1;
                r_state    <= S_IDLE;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= S_HELD;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // 9999*10 + 9 needs 17 bits before the modulo.
  assign w_shift = 17'(data_out) * 17'd10 + 17'(r_cand);
  assign w_wrap  = 16'(w_shift % 17'd10000);
  assign w_div   = data_out / 16'd10;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      pressed   <= 1'b0;
      data_out  <= 16'd0;
    end else begin
      key_valid <= r_acc;
      if (r_acc) begin
        key_code <= r_cand;
        pressed  <= 1'b1;
        if (r_cand <= 4'd9) begin
          data_out <= w_wrap;
        end else if (r_cand == 4'hB) begin
          data_out <= w_div;
        end else if (r_cand == 4'hC) begin
          data_out <= 16'd0;
        end
      end else if (r_rel_done) begin
        pressed <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
//==============================================================================
// Module   : tb_keypad_scan
// Purpose  : Directed self-checking bench for keypad_scan (4 ticks, 2 scans).
// Revision : 1.0 - initial release
//==============================================================================
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        pressed;
  logic [15:0] data_out;

  logic [15:0] keys;
  int          total = 0;
  int          bad = 0;
  int          n_kv = 0;
  int          n_consec = 0;
  logic        prev_kv = 1'b0;
  int          base;
  int          lat;

  keypad_scan #(
    .SCAN_TICKS    (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .pressed  (pressed),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_kv = n_kv + 1;
      if (prev_kv === 1'b1) n_consec = n_consec + 1;
    end
    prev_kv = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge where col wraps 0111 -> 1110 (start of a scan).
  task automatic align();
    logic [3:0] prev;
    int         k;
    logic       found;
    prev  = col;
    found = 1'b0;
    k     = 0;
    while (!found && k < 40) begin
      @(posedge clk);
      #1;
      if (col == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = col;
      k++;
    end
    check("align", 32'(found), 32'd1);
  endtask

  task automatic tap(input int idx);
    align();
    keys = 16'(32'd1 << idx);
    cyc(48);
    keys = 16'h0;
    cyc(48);
  endtask

  task automatic wait_kv(output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst  = 1'b0;
    keys = 16'h0;
    cyc(3);
    @(negedge clk) rst = 1'b1;
    cyc(6);

    // Reset mid-count, then column rotation.
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst_col", 32'(col), 32'h E);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_pressed", 32'(pressed), 32'd0);
    check("rst_kv", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    @(negedge clk) rst = 1'b1;
    cyc(4);  check("col_1", 32'(col), 32'h D);
    cyc(4);  check("col_2", 32'(col), 32'h B);
    cyc(4);  check("col_3", 32'(col), 32'h 7);
    cyc(4);  check("col_0", 32'(col), 32'h E);

    // Digit 7: latency and single event.
    base = n_kv;
    align();
    keys = 16'(32'd1 << 8);
    wait_kv(lat);
    check("lat_7", 32'(lat), 32'd33);
    check("code_7", 32'(key_code), 32'h7);
    check("data_7", 32'(data_out), 32'd7);
    cyc(15);
    check("held_7", 32'(pressed), 32'd1);
    keys = 16'h0;
    cyc(48);
    check("rel_7", 32'(pressed), 32'd0);
    check("once_7", 32'(n_kv - base), 32'd1);

    tap(0); tap(1); tap(2);
    check("data_7123", 32'(data_out), 32'd7123);
    tap(4);
    check("data_wrap", 32'(data_out), 32'd1234);

    // Bounce: "5" for one scan only.
    base = n_kv;
    align();
    keys = 16'(32'd1 << 5);
    cyc(16);
    keys = 16'h0;
    cyc(48);
    check("bounce_kv", 32'(n_kv - base), 32'd0);
    check("bounce_data", 32'(data_out), 32'd1234);
    check("bounce_pr", 32'(pressed), 32'd0);

    // Two keys together: no event.
    base = n_kv;
    align();
    keys = 16'h0003;
    cyc(80);
    keys = 16'h0;
    cyc(48);
    check("multi_kv", 32'(n_kv - base), 32'd0);
    check("multi_data", 32'(data_out), 32'd1234);

    // Hold 4, then add 8.
    base = n_kv;
    align();
    keys = 16'(32'd1 << 4);
    cyc(48);
    check("hold4_kv", 32'(n_kv - base), 32'd1);
    keys = keys | 16'(32'd1 << 9);
    cyc(48);
    check("add8_kv", 32'(n_kv - base), 32'd1);
    check("add8_code", 32'(key_code), 32'h4);
    check("add8_pr", 32'(pressed), 32'd1);
    keys = 16'h0;
    cyc(48);
    check("add8_data", 32'(data_out), 32'd2344);

    // Edit keys.
    tap(11);
    check("clr0", 32'(data_out), 32'd0);
    tap(0); tap(1); tap(2);
    check("data_123", 32'(data_out), 32'd123);
    tap(7);
    check("bksp", 32'(data_out), 32'd12);
    tap(11);
    check("clear", 32'(data_out), 32'd0);
    base = n_kv;
    tap(3);
    check("a_kv", 32'(n_kv - base), 32'd1);
    check("a_code", 32'(key_code), 32'hA);
    check("a_data", 32'(data_out), 32'd0);
    base = n_kv;
    align();
    keys = 16'(32'd1 << 7);
    cyc(160);
    keys = 16'h0;
    cyc(48);
    check("bhold_kv", 32'(n_kv - base), 32'd1);
    check("bhold_data", 32'(data_out), 32'd0);

    // Reset while HELD, key stays down.
    align();
    keys = 16'(32'd1 << 0);
    cyc(48);
    check("pre_rst_pr", 32'(pressed), 32'd1);
    check("pre_rst_data", 32'(data_out), 32'd1);
    @(negedge clk) rst = 1'b0;
    #1;
    check("mid_rst_pr", 32'(pressed), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    @(negedge clk) rst = 1'b1;
    wait_kv(lat);
    check("post_rst_lat", 32'(lat), 32'd33);
    check("post_rst_code", 32'(key_code), 32'h1);
    check("post_rst_data", 32'(data_out), 32'd1);
    keys = 16'h0;
    cyc(48);

    check("no_back2back", 32'(n_consec), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Scanner for a 4x4 hex keypad that produces the 16-bit value shown on the four-digit seven-segment display. It drives one keypad column low at a time, samples the row lines, debounces per full scan, and emits one event per accepted key press. Decimal keys build a 0–9999 number in `data_out`, which connects directly to the display driver's `data_seg` input.

## Interface
- `SCAN_TICKS`, default 100000: clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to accept a press or a release; must be ≥ 1.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `row` input 4: keypad rows, active-low (pulled up). Asynchronous to `clk`.
- `col` output 4: keypad columns, active-low; exactly one bit is low at all times.
- `key_valid` output 1: one-cycle pulse when a press is accepted.
- `key_code` output 4: hex code of the last accepted key; held until the next accept.
- `pressed` output 1: high from accept until release is accepted.
- `data_out` output 16: entered decimal value, 0–9999.

## Operation
- **Keypad map**, as (row, col) → code:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: 0, F, E, D
- **Row synchronizer:** `row` passes through a 2-flop synchronizer before any use.
- **Column scan:**
  - A tick counter runs 0..SCAN_TICKS-1 per column.
  - `col` rotates 1110 → 1101 → 1011 → 0111 → 1110.
  - The synchronized row is sampled at tick SCAN_TICKS-1, the last cycle before the column changes.
- **Snapshot:** a full scan is the four column samples. At the col3 sample it is classified as:
  - NONE: no key down.
  - ONE(k): exactly one key down.
  - MULTI: two or more keys down.
- **FSM**, evaluated once per completed scan:
  - **IDLE:**
    - ONE(k) → CAND, with cand=k and cnt=1.
    - If DEBOUNCE_SCANS=1, ONE(k) accepts immediately instead.
  - **CAND:**
    - ONE(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - ONE(other) → restart CAND with the new key and cnt=1.
    - NONE or MULTI → IDLE.
  - **HELD:**
    - NONE → REL, with cnt=1.
    - Anything else → stay in HELD. There is no auto-repeat, and extra keys are ignored.
  - **REL:**
    - NONE → cnt+1; when cnt reaches DEBOUNCE_SCANS, go to IDLE and drop `pressed`.
    - Anything non-NONE → back to HELD.
- **Accept actions:** `key_valid`=1 for one cycle, `key_code`=cand, `pressed`=1.
- **`data_out` update on accept:**
  - Digit d (0–9): `data_out` = (`data_out`·10 + d) mod 10000. Compute in at least 17 bits (max 99999) before the reduction.
  - B (backspace): `data_out` = `data_out` / 10, integer division.
  - C (clear): `data_out` = 0.
  - A, D, E, F: `data_out` unchanged; `key_valid` still pulses.
- **Reset (`rst`=0):**
  - Takes effect immediately, regardless of state.
  - Outputs: `col`=1110, `key_valid`=0, `key_code`=0, `pressed`=0, `data_out`=0.
  - Internal: FSM=IDLE, counters=0, synchronizer=1111.

## Timing
- One full scan lasts 4·SCAN_TICKS cycles.
- FSM evaluation happens on the col3 sample edge.
- `key_valid`, `key_code`, `pressed` and `data_out` all update on the clock edge after that evaluation (registered, 1-cycle latency).
- Minimum press-to-`key_valid` time, for a key down from the start of a scan: DEBOUNCE_SCANS full scans + 1 cycle.
- Synchronizer latency is 2 cycles. A row change must be stable at least 2 cycles before the sample tick to be seen in that scan.
- `key_valid` never asserts on two consecutive cycles; at most one assertion per full scan.
- After release is accepted, a new press needs a fresh DEBOUNCE_SCANS in CAND.

## Test plan
Benches use SCAN_TICKS=4 and DEBOUNCE_SCANS=2, and model the keypad as row[r]=0 when key (r,c) is down and col[c]=0.

- **Reset values:** drive `rst`=0 mid-count, then release → `col`=1110, `data_out`=0, `pressed`=0, `key_valid`=0. `col` then steps every 4 cycles through 1101, 1011, 0111.
- **Digit entry and wrap:**
  - Press "7" for 3 scans, then release → exactly one `key_valid`, `key_code`=7, `data_out`=7.
  - Then enter 1, 2, 3, 4 → `data_out`=7123, then 1234 (mod-10000 wrap).
- **Bounce rejection:** key "5" down for exactly 1 scan, then up → no `key_valid`, `data_out` unchanged, FSM back to IDLE.
- **Multiple keys:**
  - 1 and 2 down together for 5 scans → no event.
  - Hold "4" until accepted, then add "8" → no second event; `key_code` stays 4.
- **Edit keys:** with `data_out`=123:
  - B → 12.
  - C → 0.
  - A → `key_valid` with `key_code`=A, `data_out` still 0.
  - Holding B for 10 scans → a single event only.
- **Reset mid-hold:** pulse `rst` low while in HELD → `pressed`=0 immediately and `data_out`=0. With the key still held after reset, one new `key_valid` follows after 2 scans.
